spi_tx_frame_feeder: RTL
========================

# spi_tx_frame_feeder

Upstream feeder for the SPI slave byte transmitter. Buffers framed bytes from the system side and pushes them into the transmitter's write port only while the SPI master holds chip-select active and the transmitter has room. Latches the per-frame response latency (`send_momment`) at chip-select assertion and detects aborted frames. Sits in the `clock` domain between the protocol/response logic and the transmitter PHY.

## Interface
- `DEPTH`, 16: byte buffer depth; power of two, at least 4.
- `WR_GAP`, 2: minimum idle cycles between two `send_valid` pulses; covers the PHY full-flag update latency.
- `clock` input 1: system clock; all logic rises on it.
- `rst` input 1: asynchronous, active-high reset.
- `in_data` input 8: byte from the upstream producer.
- `in_last` input 1: marks `in_data` as the final byte of its frame.
- `in_valid` input 1: byte offered this cycle.
- `in_ready` output 1: buffer can accept the byte; a transfer occurs when `in_valid && in_ready`.
- `cfg_momment` input 24: response latency in SCK edges; sampled at each chip-select rise.
- `send_flag` input 1: chip-select active, already synchronised into `clock`.
- `phy_room` input 1: the transmitter can accept a byte (its `empty` output).
- `send_data` output 8: byte sent to the transmitter.
- `send_valid` output 1: single-cycle write strobe to the transmitter.
- `send_momment` output 24: latched latency, driven to the transmitter.
- `level` output $clog2(DEPTH)+1: number of bytes held in the buffer.
- `frame_done` output 1: one-cycle pulse when a frame completes normally.
- `frame_abort` output 1: one-cycle pulse when chip-select drops mid-frame.

## Operation
- The buffer is 9 bits wide: `{last, data}`. `in_ready = (level != DEPTH)`. A simultaneous push and pop leaves `level` unchanged.
- `flag_d` is `send_flag` delayed by one register.
  - Rise: `send_flag && !flag_d`.
  - Fall: `!send_flag && flag_d`.
- State machine:
  - **IDLE**
    - Bytes accumulate in the buffer (preload).
    - On a rise: `send_momment <= cfg_momment`, then go to STREAM.
  - **STREAM**
    - Issues a byte when the buffer is non-empty, `phy_room=1`, and `gap_cnt==0`.
    - An issue pops one entry, registers `send_data`, pulses `send_valid`, and sets `gap_cnt <= WR_GAP`.
    - `gap_cnt` decrements to 0 and saturates there.
    - If the popped entry has `last=1`, go to DRAIN.
    - A fall goes to FLUSH and pulses `frame_abort`. A fall takes priority over an issue in the same cycle.
  - **DRAIN**
    - No issues.
    - On a fall: pulse `frame_done` and go to IDLE.
  - **FLUSH**
    - Pops and discards one entry per cycle while the buffer is non-empty.
    - When the popped entry has `last=1`, go to IDLE.
    - An empty buffer waits in FLUSH.
    - A rise during FLUSH is ignored.
- `send_momment` holds its value until the next rise.

## Timing
- Reset values:
  - State = IDLE; `flag_d=0`, `gap_cnt=0`.
  - `send_data=0`, `send_valid=0`, `send_momment=0`, `frame_done=0`, `frame_abort=0`.
  - `level=0`, `in_ready=1`. Buffer contents are discarded.
- Reset mid-frame drops all buffered bytes. Because `flag_d` resets to 0, a `send_flag` already high at reset release is treated as a rise.
- Outputs are registered.
  - Rise detected in cycle R: state is STREAM in R+1, and the earliest `send_valid` is in R+2.
  - Consecutive `send_valid` pulses are at least `WR_GAP+1` cycles apart.
  - `frame_done` and `frame_abort` are asserted the cycle after the fall cycle.
- `level` reflects pushes and pops of the previous cycle. A byte pushed in cycle N can be issued in cycle N+2 at the earliest.
- `phy_room` is sampled in the decision cycle. `send_valid` is never asserted when `phy_room` was 0 in that cycle.

## Configuration
- `SPI_TX_FEED_STATS_EN` defined:
  - Adds outputs `frame_cnt[15:0]` and `abort_cnt[15:0]`.
  - Each counts pulses of `frame_done` / `frame_abort` respectively.
  - Both wrap at 16'hFFFF→0 and reset to 0.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

## Structure
- Package `spi_phy_pkg` holds:
  - the state encoding (IDLE=2'd0, STREAM=2'd1, DRAIN=2'd2, FLUSH=2'd3);
  - the `MOMENT_W=24` constant;
  - the byte-entry width constant `ENTRY_W=9`.
- Sub-module `byte_fifo_sync`: single-clock FIFO, parameterised by `DEPTH` and width, with first-word-fall-through, `level`, full, and empty.

## Test plan
- **Reset:** assert `rst` mid-stream → all outputs at reset values, `in_ready=1`, `level=0`.
- **Normal frame:**
  - Stimulus: preload 0xA5, 0x5A, 0x3C(last) in IDLE, `cfg_momment=5`, raise `send_flag` at R with `phy_room=1`.
  - Response: `send_momment=5`; `send_valid` in R+2, R+5, R+8 carrying 0xA5, 0x5A, 0x3C.
  - Drop `send_flag` → `frame_done` one cycle.
- **Back-pressure:** `phy_room=0` for 10 cycles in STREAM → no `send_valid`; `phy_room=1` → next byte issued on the following cycle.
- **Abort:**
  - Stimulus: 6-byte frame, `send_flag` falls after 2 issues.
  - Response: `frame_abort` pulse; remaining 4 bytes discarded; `level=0`.
  - A following frame 0x11(last) is issued after the next rise.
- **Full:**
  - Stimulus: 16 pushes with `send_flag=0`.
  - Response: `level=16`, `in_ready=0`; a 17th offered byte is not accepted; one pop → `in_ready=1`.
- **Stats (`SPI_TX_FEED_STATS_EN`):** two normal frames and one abort → `frame_cnt=2`, `abort_cnt=1`.

Source files
------------

// File: rtl/spi_phy_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_phy_pkg                                                          |
// | Shared encodings and widths for the SPI transmit feeder.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package spi_phy_pkg;

    localparam int MOMENT_W = 24;
    localparam int ENTRY_W  = 9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FLUSH  = 2'd3
    } feed_state_t;

    function automatic logic entry_is_last(input logic [ENTRY_W-1:0] entry);
        return entry[ENTRY_W-1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_tx_frame_feeder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_tx_frame_feeder_if                                               |
// | Upstream byte stream plus transmitter write port of the feeder.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface spi_tx_frame_feeder_if;
    import spi_phy_pkg::*;

    logic [7:0]          in_data;
    logic                in_last;
    logic                in_valid;
    logic                in_ready;
    logic [7:0]          send_data;
    logic                send_valid;
    logic [MOMENT_W-1:0] send_momment;
    logic                phy_room;

    modport master (
        output in_data, in_last, in_valid, phy_room,
        input  in_ready, send_data, send_valid, send_momment
    );

    modport slave (
        input  in_data, in_last, in_valid, phy_room,
        output in_ready, send_data, send_valid, send_momment
    );
endinterface
`default_nettype wire

// File: rtl/byte_fifo_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | byte_fifo_sync                                                       |
// | Single-clock first-word-fall-through FIFO with occupancy count.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module byte_fifo_sync
    import spi_phy_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = ENTRY_W
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             push;
    logic             pop;

    // Extra pointer bit distinguishes full from empty when the indices match
    assign level   = wr_ptr_q - rd_ptr_q;
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/spi_tx_frame_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_tx_frame_feeder                                                  |
// | Gates buffered frame bytes into the SPI transmitter while CS is      |
// | active; optional counters under SPI_TX_FEED_STATS_EN.                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module spi_tx_frame_feeder
    import spi_phy_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int WR_GAP = 2
) (
    input  logic                   clock,
    input  logic                   rst,
    spi_tx_frame_feeder_if.slave   bus,
    input  logic [MOMENT_W-1:0]    cfg_momment,
    input  logic                   send_flag,
    output logic [$clog2(DEPTH):0] level,
    output logic                   frame_done,
    output logic                   frame_abort
`ifdef SPI_TX_FEED_STATS_EN
    ,
    output logic [15:0]            frame_cnt,
    output logic [15:0]            abort_cnt
`endif
);
    localparam int GAP_W = $clog2(WR_GAP + 2);

    feed_state_t         state_q, state_d;
    logic                flag_q;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [7:0]          data_q, data_d;
    logic                valid_q, valid_d;
    logic [MOMENT_W-1:0] mom_q, mom_d;
    logic                done_q, done_d;
    logic                abort_q, abort_d;

    logic                pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [ENTRY_W-1:0]  fifo_dout;
    logic                rise;
    logic                fall;

    byte_fifo_sync #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clock   (clock),
        .rst     (rst),
        .wr_en   (bus.in_valid),
        .wr_data ({bus.in_last, bus.in_data}),
        .rd_en   (pop),
        .rd_data (fifo_dout),
        .level   (level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign rise = send_flag && !flag_q;
    assign fall = !send_flag && flag_q;

    assign bus.in_ready     = !fifo_full;
    assign bus.send_data    = data_q;
    assign bus.send_valid   = valid_q;
    assign bus.send_momment = mom_q;
    assign frame_done       = done_q;
    assign frame_abort      = abort_q;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            flag_q  <= 1'b0;
            gap_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            mom_q   <= '0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            flag_q  <= send_flag;
            gap_q   <= gap_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            mom_q   <= mom_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gap_d   = (gap_q != '0) ? gap_q - GAP_W'(1) : gap_q;
        data_d  = data_q;
        valid_d = 1'b0;
        mom_d   = mom_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    mom_d   = cfg_momment;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                // Chip-select loss wins over a same-cycle issue
                if (fall) begin
                    abort_d = 1'b1;
                    state_d = ST_FLUSH;
                end else if (!fifo_empty && bus.phy_room && (gap_q == '0)) begin
                    pop     = 1'b1;
                    data_d  = fifo_dout[7:0];
                    valid_d = 1'b1;
                    gap_d   = GAP_W'(WR_GAP);
                    if (entry_is_last(fifo_dout)) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fall) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    if (entry_is_last(fifo_dout)) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef SPI_TX_FEED_STATS_EN
    logic [15:0] frame_cnt_q;
    logic [15:0] abort_cnt_q;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
            abort_cnt_q <= '0;
        end else begin
            if (done_q)  frame_cnt_q <= frame_cnt_q + 16'd1;
            if (abort_q) abort_cnt_q <= abort_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign abort_cnt = abort_cnt_q;
`endif

endmodule
`default_nettype wire
